// File: rtl/demo_scene_sequencer_if.sv
// Frame-control bundle between the sync/control side and the scene sequencer.
// The master drives vsync/pause/skip; the slave returns per-frame pattern parameters.
interface demo_scene_sequencer_if;
    logic       vsync;
    logic       pause;
    logic       skip;
    logic [1:0] scene;
    logic [9:0] scroll;
    logic [7:0] noise_mask_x;
    logic [7:0] noise_mask_y;
    logic [1:0] fade;
    logic [1:0] phase;
    logic       scene_start;

    modport master (
        output vsync, pause, skip,
        input  scene, scroll, noise_mask_x, noise_mask_y, fade, phase, scene_start
    );

    modport slave (
        input  vsync, pause, skip,
        output scene, scroll, noise_mask_x, noise_mask_y, fade, phase, scene_start
    );
endinterface

// File: rtl/demo_scene_sequencer.sv
// Per-frame scene sequencer: detects vsync rising edges and steps four scenes
// through FADE_IN / SHOW / FADE_OUT, producing registered pattern parameters.
module demo_scene_sequencer #(
    parameter int SCENE_FRAMES = 240,
    parameter int FADE_FRAMES  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    demo_scene_sequencer_if.slave        bus
);

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        SHOW     = 2'd1,
        FADE_OUT = 2'd2
    } state_t;

    // Fade level is the top two bits of pcnt inside the fade window.
    localparam int          FADE_SHIFT = $clog2(FADE_FRAMES) - 2;
    localparam logic [15:0] FADE_LAST  = 16'(FADE_FRAMES - 1);
    localparam logic [15:0] SCENE_LAST = 16'(SCENE_FRAMES - 1);

    logic        vsync_q_reg;
    state_t      state_reg,       state_next;
    logic [15:0] pcnt_reg,        pcnt_next;
    logic [1:0]  scene_reg,       scene_next;
    logic [9:0]  scroll_reg,      scroll_next;
    logic [1:0]  fade_reg,        fade_next;
    logic [7:0]  mask_x_reg,      mask_x_next;
    logic [7:0]  mask_y_reg,      mask_y_next;
    logic [1:0]  phase_reg,       phase_next;
    logic        scene_start_reg, scene_start_next;

    logic        tick;
    logic        advance;
    logic [1:0]  fade_level;

    assign tick    = bus.vsync & ~vsync_q_reg;
    assign advance = tick & ~bus.pause;

    // State register: sequencing state plus the registered output image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q_reg     <= 1'b0;
            state_reg       <= FADE_IN;
            pcnt_reg        <= '0;
            scene_reg       <= '0;
            scroll_reg      <= '0;
            fade_reg        <= '0;
            mask_x_reg      <= '0;
            mask_y_reg      <= '0;
            phase_reg       <= '0;
            scene_start_reg <= 1'b0;
        end else begin
            vsync_q_reg     <= bus.vsync;
            state_reg       <= state_next;
            pcnt_reg        <= pcnt_next;
            scene_reg       <= scene_next;
            scroll_reg      <= scroll_next;
            fade_reg        <= fade_next;
            mask_x_reg      <= mask_x_next;
            mask_y_reg      <= mask_y_next;
            phase_reg       <= phase_next;
            scene_start_reg <= scene_start_next;
        end
    end

    // Next-state logic; nothing moves unless an unpaused frame tick arrives.
    always_comb begin
        state_next       = state_reg;
        pcnt_next        = pcnt_reg;
        scene_next       = scene_reg;
        scroll_next      = scroll_reg;
        scene_start_next = 1'b0;
        if (advance) begin
            scroll_next = scroll_reg + 10'(scene_reg) + 10'd1;
            case (state_reg)
                FADE_IN: begin
                    if (pcnt_reg == FADE_LAST) begin
                        state_next = SHOW;
                        pcnt_next  = '0;
                    end else begin
                        pcnt_next = pcnt_reg + 16'd1;
                    end
                end
                SHOW: begin
                    if (bus.skip || (pcnt_reg == SCENE_LAST)) begin
                        state_next = FADE_OUT;
                        pcnt_next  = '0;
                    end else begin
                        pcnt_next = pcnt_reg + 16'd1;
                    end
                end
                FADE_OUT: begin
                    if (pcnt_reg == FADE_LAST) begin
                        state_next       = FADE_IN;
                        pcnt_next        = '0;
                        scene_next       = scene_reg + 2'd1;
                        scene_start_next = 1'b1;
                    end else begin
                        pcnt_next = pcnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_next = FADE_IN;
                    pcnt_next  = '0;
                end
            endcase
        end
    end

    // Output logic is derived from the next state so the registered outputs
    // always agree with the scene/state/pcnt they are registered alongside.
    always_comb begin
        fade_level  = pcnt_next[FADE_SHIFT +: 2];
        phase_next  = state_next;
        fade_next   = 2'd0;
        mask_x_next = 8'h00;
        mask_y_next = 8'h00;
        case (state_next)
            FADE_IN:  fade_next = fade_level;
            SHOW:     fade_next = 2'd3;
            FADE_OUT: fade_next = 2'd3 - fade_level;
            default:  fade_next = 2'd0;
        endcase
        case (scene_next)
            2'd1:    mask_x_next = 8'h0F;
            2'd2:    mask_y_next = 8'h0F;
            2'd3: begin
                mask_x_next = 8'hFF;
                mask_y_next = 8'hFF;
            end
            default: begin
                mask_x_next = 8'h00;
                mask_y_next = 8'h00;
            end
        endcase
    end

    assign bus.scene        = scene_reg;
    assign bus.scroll       = scroll_reg;
    assign bus.noise_mask_x = mask_x_reg;
    assign bus.noise_mask_y = mask_y_reg;
    assign bus.fade         = fade_reg;
    assign bus.phase        = phase_reg;
    assign bus.scene_start  = scene_start_reg;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Scoreboard bench for demo_scene_sequencer with short fades/scenes so whole
// shows fit in a few thousand cycles.
module tb_demo_scene_sequencer;

    localparam int FADE  = 4;
    localparam int SCENE = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demo_scene_sequencer_if bus();

    demo_scene_sequencer #(
        .SCENE_FRAMES(SCENE),
        .FADE_FRAMES (FADE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [1:0] scene;
        logic [9:0] scroll;
        logic [7:0] mx;
        logic [7:0] my;
        logic [1:0] fade;
        logic [1:0] phase;
        logic       start;
    } obs_t;

    obs_t exp_q[$];
    obs_t got, exp;
    int   checks  = 0;
    int   errors  = 0;
    int   tick_no = 0;

    // Reference model of the sequencer, written from the behavioural description.
    int         m_state;
    int         m_pcnt;
    logic [1:0] m_scene;
    logic [9:0] m_scroll;
    logic       m_start;

    function automatic obs_t observe();
        obs_t o;
        o.scene  = bus.scene;
        o.scroll = bus.scroll;
        o.mx     = bus.noise_mask_x;
        o.my     = bus.noise_mask_y;
        o.fade   = bus.fade;
        o.phase  = bus.phase;
        o.start  = bus.scene_start;
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        int   k;
        k        = (m_pcnt * 4) / FADE;
        o.scene  = m_scene;
        o.scroll = m_scroll;
        o.start  = m_start;
        o.phase  = 2'(m_state);
        case (m_state)
            0:       o.fade = 2'(k);
            1:       o.fade = 2'd3;
            default: o.fade = 2'(3 - k);
        endcase
        case (m_scene)
            2'd0: begin o.mx = 8'h00; o.my = 8'h00; end
            2'd1: begin o.mx = 8'h0F; o.my = 8'h00; end
            2'd2: begin o.mx = 8'h00; o.my = 8'h0F; end
            default: begin o.mx = 8'hFF; o.my = 8'hFF; end
        endcase
        return o;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_pcnt   = 0;
        m_scene  = 2'd0;
        m_scroll = 10'd0;
        m_start  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_tick(input logic p, input logic s);
        m_start = 1'b0;
        if (!p) begin
            m_scroll = m_scroll + 10'(m_scene) + 10'd1;
            case (m_state)
                0: if (m_pcnt == FADE - 1) begin m_state = 1; m_pcnt = 0; end
                   else m_pcnt++;
                1: if (s || m_pcnt == SCENE - 1) begin m_state = 2; m_pcnt = 0; end
                   else m_pcnt++;
                default: if (m_pcnt == FADE - 1) begin
                       m_state = 0; m_pcnt = 0; m_scene = m_scene + 2'd1; m_start = 1'b1;
                   end else m_pcnt++;
            endcase
        end
    endtask

    // One vsync rising edge: low for a cycle, then high at the sampled edge.
    // vsync is left high on return.
    task automatic drive_tick(input logic p, input logic s);
        @(negedge clk);
        bus.vsync = 1'b0; bus.pause = 1'b0; bus.skip = 1'b0;
        @(negedge clk);
        bus.vsync = 1'b1; bus.pause = p; bus.skip = s;
        model_tick(p, s);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        tick_no++;
        $display("tick %0d pause=%0b skip=%0b -> scene=%0d phase=%0d fade=%0d scroll=%0d start=%0b",
                 tick_no, p, s, bus.scene, bus.phase, bus.fade, bus.scroll, bus.scene_start);
    endtask

    task automatic test_reset();
        bus.vsync = 1'b0; bus.pause = 1'b0; bus.skip = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", got, obs_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequencing();
        logic [1:0] fade_ref [0:2];
        fade_ref[0] = 2'd1; fade_ref[1] = 2'd2; fade_ref[2] = 2'd3;
        for (int i = 1; i <= 16; i++) begin
            drive_tick(1'b0, 1'b0);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL seq_tick%0d: got %h expected %h", i, got, exp);
            end
            if (i <= 3) begin
                checks++;
                if (got.fade !== fade_ref[i-1]) begin
                    errors++;
                    $display("FAIL seq_fade%0d: got %0d expected %0d", i, got.fade, fade_ref[i-1]);
                end
            end
            if (i == 4 || i == 12) begin
                checks++;
                if (got.phase !== ((i == 4) ? 2'd1 : 2'd2)) begin
                    errors++;
                    $display("FAIL seq_phase%0d: got %0d expected %0d", i, got.phase, (i == 4) ? 1 : 2);
                end
            end
        end
        checks++;
        if (got.scene !== 2'd1 || got.start !== 1'b1) begin
            errors++;
            $display("FAIL seq_scene_start: got scene=%0d start=%0b expected scene=1 start=1",
                     got.scene, got.start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.scene_start !== 1'b0) begin
            errors++;
            $display("FAIL seq_start_width: got %0b expected 0", bus.scene_start);
        end
        m_start = 1'b0;
    endtask

    task automatic test_edge_detect();
        drive_tick(1'b0, 1'b0);
        exp = exp_q.pop_front();
        repeat (99) @(posedge clk);
        #1;
        got = observe();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL edge_hold: got %h expected %h", got, exp);
        end
        checks++;
        if (got.mx !== 8'h0F || got.my !== 8'h00) begin
            errors++;
            $display("FAIL edge_masks: got %h/%h expected 0f/00", got.mx, got.my);
        end
    endtask

    task automatic test_skip();
        int guard;
        guard = 0;
        while (m_state == 0 && guard < 20) begin
            drive_tick(1'b0, 1'b1);
            guard++;
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL skip_in_fade_in: got %h expected %h", got, exp);
            end
        end
        drive_tick(1'b0, 1'b0);
        void'(exp_q.pop_front());
        drive_tick(1'b0, 1'b1);
        got = observe();
        exp = exp_q.pop_front();
        checks++;
        if (got.phase !== 2'd2 || got.fade !== 2'd3 || got !== exp) begin
            errors++;
            $display("FAIL skip_show: got %h expected %h (phase 2 fade 3)", got, exp);
        end
        // skip is ignored through FADE_OUT and, with pause, in SHOW
        for (int i = 0; i < 8; i++) begin
            drive_tick(1'b0, (i < 4));
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL skip_fade_out%0d: got %h expected %h", i, got, exp);
            end
        end
        drive_tick(1'b1, 1'b1);
        got = observe();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp || got.phase !== 2'd1) begin
            errors++;
            $display("FAIL skip_with_pause: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_pause();
        for (int i = 0; i < 10; i++) begin
            drive_tick(1'b1, 1'b0);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pause%0d: got %h expected %h", i, got, exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive_tick(1'b0, 1'b0);
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pause_resume%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_scroll_wrap();
        logic [9:0] prev;
        logic       wrapped;
        int         n;
        wrapped = 1'b0;
        n       = 0;
        prev    = bus.scroll;
        while (!wrapped && n < 2500) begin
            drive_tick(1'b0, 1'b0);
            n++;
            got = observe();
            exp = exp_q.pop_front();
            if (got !== exp) begin
                checks++;
                errors++;
                $display("FAIL wrap_tick%0d: got %h expected %h", n, got, exp);
            end
            if (got.scroll < prev && got.scene == 2'd3) wrapped = 1'b1;
            prev = got.scroll;
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL scroll_wrap: got no wrap in scene 3 after %0d ticks, required a wrap", n);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!(m_scene == 2'd2 && m_state == 1 && m_pcnt == 2) && guard < 200) begin
            drive_tick(1'b0, 1'b0);
            void'(exp_q.pop_front());
            guard++;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== obs_t'(0) || guard >= 200) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", got, obs_t'(0));
        end
        model_reset();
        bus.vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.scene_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_start: got %0b expected 0", bus.scene_start);
        end
    endtask

    task automatic test_reset_release();
        @(negedge clk);
        rst_n     = 1'b1;
        bus.vsync = 1'b1;
        model_tick(1'b0, 1'b0);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        got = observe();
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL release_tick: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            drive_tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            got = observe();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b%0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequencing();
        test_edge_detect();
        test_skip();
        test_pause();
        test_scroll_wrap();
        test_reset_mid();
        test_reset_release();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demo_scene_sequencer.md
# demo_scene_sequencer

Frame-rate controller for the VGA pattern datapath. It detects each new frame from the sync generator's `vsync`, steps a four-scene show through fade-in, show and fade-out phases, and drives the per-frame parameters the pattern logic consumes: scroll offset, noise masks, fade level and scene index. It replaces the free-running `posedge vsync` counter with a clean single-clock sequencer.

## Interface

**Parameters**
- `SCENE_FRAMES`, default 240: frames spent in SHOW per scene; legal range 1..65535.
- `FADE_FRAMES`, default 16: frames per fade phase; power of two, 4..1024.

**Ports**
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `vsync`  in  1: from hvsync generator, synchronous to `clk`.
- `pause`  in  1: level; while 1, frame ticks are ignored.
- `skip`  in  1: level, sampled on frame ticks; ends SHOW early.
- `scene`  out  2: current scene index, 0..3.
- `scroll`  out  10: horizontal scroll offset.
- `noise_mask_x`  out  8: mask ANDed with PRNG/user bits for x noise.
- `noise_mask_y`  out  8: mask for y noise.
- `fade`  out  2: brightness, 0 = black, 3 = full.
- `phase`  out  2: 0 = FADE_IN, 1 = SHOW, 2 = FADE_OUT.
- `scene_start`  out  1: one-cycle pulse on entry to FADE_IN of a new scene.

## Operation

- **Frame tick**
  - `vsync_q` registers `vsync`.
  - tick = `vsync & ~vsync_q`.
  - One tick per rising edge; `vsync` held high yields no further ticks.
- **Counters**
  - `pcnt` is a 16-bit phase-frame counter.
  - The FSM advances only on ticks with `pause`=0.
  - Ticks with `pause`=1 change nothing: no scroll, no `pcnt`, no skip.
- **FADE_IN**
  - Each tick increments `pcnt`.
  - On a tick with `pcnt`=FADE_FRAMES-1: go to SHOW, `pcnt`=0.
- **SHOW**
  - Tick with `skip`=1: go to FADE_OUT, `pcnt`=0.
  - Otherwise, tick with `pcnt`=SCENE_FRAMES-1: go to FADE_OUT, `pcnt`=0.
  - Otherwise the tick increments `pcnt`.
- **FADE_OUT**
  - On a tick with `pcnt`=FADE_FRAMES-1: `scene` becomes `scene`+1 mod 4, go to FADE_IN, `pcnt`=0, pulse `scene_start`.
- **skip**
  - Ignored in FADE_IN and FADE_OUT.
  - `pause` takes priority over `skip`.
- **scroll**
  - On every non-paused tick, `scroll` ← `scroll` + (`scene`+1), using the `scene` value before that tick's update.
  - Modulo 1024; wraps silently.
- **fade**, with k = (`pcnt`·4)/FADE_FRAMES, i.e. the top two bits of `pcnt` within the fade range:
  - FADE_IN: k.
  - SHOW: 3.
  - FADE_OUT: 3−k.
- **Noise masks** (x / y), a function of `scene` only:
  - scene 0: 00 / 00
  - scene 1: 0F / 00
  - scene 2: 00 / 0F
  - scene 3: FF / FF
- **Outputs**: all registered and mutually consistent. In any cycle, `fade`, the masks and `phase` reflect the current `scene`/state/`pcnt`.
- **Reset values**:
  - state FADE_IN, `scene`=0, `pcnt`=0, `scroll`=0, `fade`=0.
  - masks 00/00, `phase`=0, `scene_start`=0, `vsync_q`=0.
  - No `scene_start` pulse is produced by reset.
- **Reset mid-operation**: asynchronous return to the reset values in any state; sequencing restarts at scene 0 FADE_IN on the first tick after release.

## Timing

- Tick latency: rising `vsync` sampled at edge N (`vsync`=1, `vsync_q`=0). All outputs show the updated values after edge N.
- `scene_start` is high for exactly the one cycle following edge N of the FADE_OUT→FADE_IN transition.
- Frame cadence, with no pause and no skip: each scene lasts 2·FADE_FRAMES + SCENE_FRAMES ticks. Default total 272 frames.
- `pause` and `skip` must be stable at the tick edge; they are not synchronized internally.
- If `vsync` rises in the same cycle `rst_n` deasserts, with `vsync_q`=0 after reset, it counts as a tick.

## Test plan

- **Reset**: assert `rst_n`=0 mid-SHOW of scene 2 -> all outputs immediately at reset values; `scene_start` stays 0.
- **Sequencing** (FADE_FRAMES=4, SCENE_FRAMES=8): 16 ticks -> `phase` 0,1,2 at ticks 4 and 12; `scene`=1 and one `scene_start` pulse after tick 16; `fade` sequence across the first 4 ticks 0→1→2→3.
- **Scroll wrap**: run in scene 3 (+4 per tick) from `scroll`=1020 -> next tick gives `scroll`=0; scene 0 ticks give +1.
- **Pause**: `pause`=1 for 10 vsync pulses in SHOW -> `scroll`, `pcnt`, `phase` and `fade` unchanged; resume continues from the same values.
- **Skip**:
  - `skip`=1 at tick 2 of SHOW -> `phase`=2, `fade`=3 next.
  - `skip`=1 during FADE_IN -> no effect.
  - `skip`=1 with `pause`=1 -> no effect.
- **Edge detect**: `vsync` held high 100 cycles -> exactly one tick; masks in scene 1 read 0F/00.
